// File: rtl/pass_display_ctrl.sv
// pass_display_ctrl: LED/7-seg status driver for the password lock with blink, fail counting and timed lockout.
// Optional PASS_DISPLAY_ATTEMPTS_EN shows remaining attempts on digit 0 in IDLE/ENTRY.
module pass_display_ctrl #(
    parameter int N_DIGITS   = 5,
    parameter int N_LEDS     = 10,
    parameter int STATE_W    = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int MAX_FAILS  = 3,
    parameter int LOCK_TICKS = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STATE_W-1:0]    state,
    output logic [N_LEDS-1:0]     leds_out,
    output logic [7*N_DIGITS-1:0] seg_out,
    output logic [3:0]            fail_cnt,
    output logic                  locked
);
    localparam int CW = $clog2(BLINK_DIV);
    localparam int LW = $clog2(LOCK_TICKS + 1);
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_E     = 7'b0000110;
    localparam logic [6:0] G_R     = 7'b0101111;
    localparam logic [6:0] G_O     = 7'b1000000;
    localparam logic [6:0] G_P     = 7'b0001100;
    localparam logic [6:0] G_N     = 7'b0101011;
    localparam logic [6:0] G_L     = 7'b1000111;
    localparam logic [6:0] G_C     = 7'b1000110;

    typedef enum logic {RUN, LOCK} lock_t;

    lock_t                  lock_q, lock_n;
    logic [STATE_W-1:0]     state_q;
    logic [CW-1:0]          cnt_q, cnt_n;
    logic                   phase_q, phase_n;
    logic [3:0]             fail_n;
    logic [LW-1:0]          lcnt_q, lcnt_n;
    logic                   tick, err_edge;
    logic [N_LEDS-1:0]      leds_n;
    logic [7*N_DIGITS-1:0]  seg_n;
    logic [3:0][6:0]        txt;
    logic [2:0]             len;
    logic [6:0]             fill;

`ifdef PASS_DISPLAY_ATTEMPTS_EN
    function automatic logic [6:0] dec_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return G_BLANK;
        endcase
    endfunction
`endif

    assign tick     = cnt_q == CW'(BLINK_DIV - 1);
    assign err_edge = lock_q == RUN && state == STATE_W'(5) && state_q != STATE_W'(5);

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q   <= RUN;
            state_q  <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b1;
            lcnt_q   <= '0;
            fail_cnt <= '0;
            locked   <= 1'b0;
            leds_out <= '0;
            seg_out  <= {N_DIGITS{G_DASH}};
        end else begin
            lock_q   <= lock_n;
            state_q  <= state;
            cnt_q    <= cnt_n;
            phase_q  <= phase_n;
            lcnt_q   <= lcnt_n;
            fail_cnt <= fail_n;
            locked   <= lock_n == LOCK;
            leds_out <= leds_n;
            seg_out  <= seg_n;
        end
    end

    // An error edge restarts the timebase so ERROR always opens on the visible phase.
    always_comb begin
        lock_n  = lock_q;
        lcnt_n  = lcnt_q;
        fail_n  = fail_cnt;
        cnt_n   = tick ? '0 : cnt_q + 1'b1;
        phase_n = tick ? ~phase_q : phase_q;
        if (lock_q == LOCK) begin
            if (tick) begin
                lcnt_n = lcnt_q + 1'b1;
                if (lcnt_q == LW'(LOCK_TICKS - 1)) begin
                    lock_n = RUN;
                    lcnt_n = '0;
                    fail_n = '0;
                end
            end
        end else if (state == STATE_W'(4)) begin
            fail_n = '0;
        end else if (err_edge) begin
            cnt_n   = '0;
            phase_n = 1'b1;
            lcnt_n  = '0;
            fail_n  = fail_cnt < 4'(MAX_FAILS) ? fail_cnt + 1'b1 : fail_cnt;
            lock_n  = fail_cnt == 4'(MAX_FAILS - 1) ? LOCK : RUN;
        end
    end

    // Outputs are decoded from next-cycle values so they land one clock after the state input.
    always_comb begin
        txt  = {G_BLANK, G_BLANK, G_BLANK, G_BLANK};
        len  = 3'd0;
        fill = G_BLANK;
        for (int k = 0; k < N_LEDS; k++)
            leds_n[k] = 1'b0;
        if (lock_n == LOCK) begin
            txt = {G_BLANK, G_C, G_O, G_L};
            len = phase_n ? 3'd3 : 3'd0;
        end else if (state <= STATE_W'(3)) begin
            fill = G_DASH;
            for (int k = 0; k < N_LEDS; k++)
                leds_n[k] = k < int'(state);
        end else if (state == STATE_W'(4)) begin
            txt    = {G_N, G_E, G_P, G_O};
            len    = 3'd4;
            leds_n = '1;
        end else if (state == STATE_W'(5)) begin
            txt    = {G_BLANK, G_R, G_R, G_E};
            len    = phase_n ? 3'd3 : 3'd0;
            leds_n = phase_n ? '1 : '0;
        end
        for (int i = 0; i < N_DIGITS; i++)
            seg_n[7*i+:7] = (N_DIGITS - 1 - i < int'(len)) ? txt[2'(N_DIGITS - 1 - i)] : fill;
`ifdef PASS_DISPLAY_ATTEMPTS_EN
        if (lock_n == RUN && state <= STATE_W'(3))
            seg_n[6:0] = dec_glyph(4'(MAX_FAILS) - fail_n);
`endif
    end
endmodule
